cmd_fetch: RTL and testbench

- Instruction fetch/decode front end of the stack processor; sits directly upstream of the control unit and feeds it opcodes.
- Reads the command byte at the current PC from program memory over a req/ack interface.
- Splits the byte into opcode[5:0] (bits 7:2) and sub[1:0] (bits 1:0).
- For opcodes that carry an immediate, fetches IMM_BYTES further bytes (little-endian) and presents the whole decoded command to the control unit with a valid/ready handshake.

---
 rtl/cmd_fetch_pkg.sv | 32 +++
 rtl/cmd_fetch_decode.sv | 35 +++
 rtl/cmd_fetch.sv | 168 ++++++++++++++++
 tb/tb_cmd_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_fetch_pkg.sv
// rtl/cmd_fetch_pkg.sv - shared opcode constants and fetch state encoding
// Purpose: 6-bit command opcodes shared by the fetch front end and the
//          control unit, plus the fetch FSM state type.
// Ports:   none (package).
package cmd_fetch_pkg;

  localparam logic [5:0] OP_PUSH = 6'h00;
  localparam logic [5:0] OP_POP  = 6'h01;
  localparam logic [5:0] OP_DUP  = 6'h02;
  localparam logic [5:0] OP_SWAP = 6'h03;
  localparam logic [5:0] OP_JMP  = 6'h10;
  localparam logic [5:0] OP_JE   = 6'h11;
  localparam logic [5:0] OP_ADD  = 6'h20;
  localparam logic [5:0] OP_SUB  = 6'h21;
  localparam logic [5:0] OP_MUL  = 6'h22;
  localparam logic [5:0] OP_DIV  = 6'h23;
  localparam logic [5:0] OP_MOV  = 6'h30;
  localparam logic [5:0] OP_MSR  = 6'h31;
  localparam logic [5:0] OP_PSR  = 6'h32;
  localparam logic [5:0] OP_PPC  = 6'h33;
  localparam logic [5:0] OP_WINT = 6'h3E;
  localparam logic [5:0] OP_HLT  = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP,
    ST_IMM,
    ST_READY,
    ST_DRAIN
  } fetch_state_e;

endpackage

// File: rtl/cmd_fetch_decode.sv
// rtl/cmd_fetch_decode.sv - combinational opcode classifier
// Purpose: tells whether an opcode is legal and whether it carries an
//          immediate. Shared with the control unit.
// Ports:   opcode_i  in  6  opcode field of a command byte
//          has_imm_o out 1  opcode is followed by immediate bytes
//          legal_o   out 1  opcode is in the legal set
module cmd_decode
  import cmd_fetch_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       has_imm_o,
  output logic       legal_o
);

  always_comb begin
    has_imm_o = 1'b0;
    legal_o   = 1'b0;
    case (opcode_i)
      OP_PUSH, OP_JMP, OP_JE: begin
        has_imm_o = 1'b1;
        legal_o   = 1'b1;
      end
      OP_POP, OP_DUP, OP_SWAP,
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_MOV, OP_MSR, OP_PSR, OP_PPC,
      OP_WINT, OP_HLT: begin
        legal_o = 1'b1;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cmd_fetch.sv
// rtl/cmd_fetch.sv - command fetch/decode front end of the stack processor
// Purpose: fetches the command byte at pc_in, splits it into opcode/sub,
//          fetches IMM_BYTES little-endian immediate bytes when required and
//          presents the decoded command with a valid/ready handshake.
// Ports:   clk, rst_n                      clock, async active-low reset
//          pc_in, flush                    next command address, discard
//          mem_req/mem_addr/mem_ack/mem_rdata  program memory read port
//          cmd_valid/cmd_ready             command handshake
//          opcode, sub, imm, cmd_len, illegal  decoded command
module cmd_fetch
  import cmd_fetch_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int IMM_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      pc_in,
  input  logic                   flush,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [7:0]             mem_rdata,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [5:0]             opcode,
  output logic [1:0]             sub,
  output logic [8*IMM_BYTES-1:0] imm,
  output logic [2:0]             cmd_len,
  output logic                   illegal
);

  localparam int              K_W     = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;
  localparam logic [K_W-1:0]  K_LAST  = K_W'(IMM_BYTES - 1);
  localparam logic [2:0]      LEN_IMM = 3'(1 + IMM_BYTES);

  fetch_state_e           state_q, state_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [5:0]             opcode_q, opcode_d;
  logic [1:0]             sub_q, sub_d;
  logic [8*IMM_BYTES-1:0] imm_q, imm_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [2:0]             len_q, len_d;
  logic                   illegal_q, illegal_d;

  logic dec_has_imm;
  logic dec_legal;

  // Classify the incoming byte directly so the OP-state ack can branch
  // without an extra cycle.
  cmd_decode u_decode (
    .opcode_i  (mem_rdata[7:2]),
    .has_imm_o (dec_has_imm),
    .legal_o   (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      opcode_q  <= '0;
      sub_q     <= '0;
      imm_q     <= '0;
      k_q       <= '0;
      len_q     <= 3'd1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      opcode_q  <= opcode_d;
      sub_q     <= sub_d;
      imm_q     <= imm_d;
      k_q       <= k_d;
      len_q     <= len_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    opcode_d  = opcode_q;
    sub_d     = sub_q;
    imm_d     = imm_q;
    k_d       = k_q;
    len_d     = len_q;
    illegal_d = illegal_q;

    case (state_q)
      ST_IDLE: begin
        // One settling cycle for the PC; addr_q doubles as the base address.
        addr_d  = pc_in;
        imm_d   = '0;
        state_d = flush ? ST_IDLE : ST_OP;
      end

      ST_OP: begin
        if (mem_ack) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            opcode_d  = mem_rdata[7:2];
            sub_d     = mem_rdata[1:0];
            illegal_d = !dec_legal;
            k_d       = '0;
            if (dec_legal && dec_has_imm) begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = ST_IMM;
            end else begin
              len_d   = 3'd1;
              state_d = ST_READY;
            end
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_IMM: begin
        if (mem_ack) begin
          if (flush) begin
            state_d = ST_IDLE;
          end else begin
            imm_d[{k_q, 3'b000} +: 8] = mem_rdata;
            k_d = k_q + K_W'(1);
            if (k_q == K_LAST) begin
              len_d   = LEN_IMM;
              state_d = ST_READY;
            end else begin
              // Address wraps naturally at 2^ADDR_W.
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end

      ST_READY: begin
        // flush takes priority over a same-cycle consume.
        if (flush || cmd_ready) begin
          state_d = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        // Keep the outstanding request alive until memory answers, then drop it.
        if (mem_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_req   = (state_q == ST_OP) || (state_q == ST_IMM) || (state_q == ST_DRAIN);
  assign mem_addr  = addr_q;
  assign cmd_valid = (state_q == ST_READY);
  assign opcode    = opcode_q;
  assign sub       = sub_q;
  assign imm       = imm_q;
  assign cmd_len   = len_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_cmd_fetch.sv
// tb/tb_cmd_fetch.sv - scoreboard bench for cmd_fetch
module tb_cmd_fetch;

  localparam int ADDR_W    = 16;
  localparam int IMM_BYTES = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [ADDR_W-1:0]      pc_in;
  logic                   flush;
  logic                   mem_req;
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_ack;
  logic [7:0]             mem_rdata;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [5:0]             opcode;
  logic [1:0]             sub;
  logic [8*IMM_BYTES-1:0] imm;
  logic [2:0]             cmd_len;
  logic                   illegal;

  always #5 clk = ~clk;

  cmd_fetch #(.ADDR_W(ADDR_W), .IMM_BYTES(IMM_BYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc_in     (pc_in),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .opcode    (opcode),
    .sub       (sub),
    .imm       (imm),
    .cmd_len   (cmd_len),
    .illegal   (illegal)
  );

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  sub;
    logic [31:0] imm;
    logic [2:0]  len;
    logic        ill;
  } exp_t;

  logic [7:0]  mem [0:65535];
  exp_t        exp_q[$];
  logic [15:0] addr_q[$];
  int          errors = 0;
  int          checks = 0;
  int          ack_delay = 1;
  bit          addr_chk = 1'b1;
  logic [5:0]  lops [16];
  int          n;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: writes the command into memory and derives the
  // expected decoded command and request address sequence from the rules.
  task automatic prep(input logic [15:0] pc, input logic [7:0] b0,
                      input logic [31:0] immv, input bit push);
    exp_t        e;
    logic [15:0] a;
    int          op;
    bit          legal, has;
    mem[pc] = b0;
    for (int i = 0; i < 4; i++) begin
      a = pc + 16'(1 + i);
      mem[a] = immv[8*i +: 8];
    end
    op    = int'(b0[7:2]);
    legal = (op <= 3) || (op == 16) || (op == 17) || (op >= 32 && op <= 35) ||
            (op >= 48 && op <= 51) || (op >= 62);
    has   = legal && (op == 0 || op == 16 || op == 17);
    e.op  = b0[7:2];
    e.sub = b0[1:0];
    e.ill = !legal;
    e.imm = 32'h0;
    e.len = 3'd1;
    if (push) addr_q.push_back(pc);
    if (has) begin
      for (int i = 0; i < 4; i++) begin
        a = pc + 16'(1 + i);
        e.imm = e.imm | (32'(mem[a]) << (8*i));
        if (push) addr_q.push_back(a);
      end
      e.len = 3'd5;
    end
    if (push) exp_q.push_back(e);
    pc_in = pc;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!cmd_valid && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("cmd_valid_seen", cmd_valid, 1'b1);
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int cnt = 0;
    while (!(mem_req && mem_addr == a) && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("req_addr_seen", {mem_req, mem_addr}, {1'b1, a});
  endtask

  task automatic consume();
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  // Memory responder: one request at a time, ack ack_delay cycles after the
  // request is first seen; a request withdrawn before its ack is forgotten.
  initial begin
    bit pend = 1'b0;
    int cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (pend) begin
        if (!mem_req) pend = 1'b0;
        else if (cnt == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          pend      = 1'b0;
        end else cnt--;
      end
      if (!mem_ack && !pend && mem_req) begin
        pend = 1'b1;
        cnt  = ack_delay - 1;
      end
    end
  end

  // Monitor: checks request addresses on every ack, output stability while
  // presented, and pops the scoreboard on each consumed command.
  initial begin
    exp_t        e;
    bit          prev_valid = 1'b0;
    bit          prev_hs    = 1'b0;
    bit          prev_pend  = 1'b0;
    logic [15:0] prev_addr  = '0;
    logic [43:0] prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_pend  = 1'b0;
        continue;
      end
      if (prev_hs) chk("valid_fall_after_consume", cmd_valid, 1'b0);
      if (prev_pend && mem_req) chk("addr_stable_while_pending", mem_addr, prev_addr);
      if (mem_req && mem_ack && addr_chk) begin
        if (addr_q.size() == 0) chk("unexpected_mem_ack", 1'b1, 1'b0);
        else chk("req_addr_order", mem_addr, addr_q.pop_front());
      end
      if (cmd_valid) begin
        chk("no_req_while_valid", mem_req, 1'b0);
        if (prev_valid) chk("outputs_held", {opcode, sub, imm, cmd_len, illegal}, prev_out);
        if (cmd_ready && !flush) begin
          if (exp_q.size() == 0) chk("unexpected_cmd", 1'b1, 1'b0);
          else begin
            e = exp_q.pop_front();
            chk("opcode", opcode, e.op);
            chk("sub", sub, e.sub);
            chk("imm", imm, e.imm);
            chk("cmd_len", cmd_len, e.len);
            chk("illegal", illegal, e.ill);
          end
        end
      end
      prev_hs    = cmd_valid && (cmd_ready || flush);
      prev_valid = cmd_valid && !prev_hs;
      prev_out   = {opcode, sub, imm, cmd_len, illegal};
      prev_pend  = mem_req && !mem_ack;
      prev_addr  = mem_addr;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    lops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h10, 6'h11, 6'h20, 6'h21,
             6'h22, 6'h23, 6'h30, 6'h31, 6'h32, 6'h33, 6'h3E, 6'h3F};
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst_n = 1'b0; flush = 1'b0; cmd_ready = 1'b0; pc_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_cmd_valid", cmd_valid, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_opcode", opcode, 6'h00);
    chk("rst_sub", sub, 2'h0);
    chk("rst_imm", imm, 32'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_cmd_len", cmd_len, 3'd1);

    // 1-byte SUB, ack one cycle after request
    prep(16'h0010, 8'h84, 32'h0, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    wait_valid(n);
    chk("latency_1byte", n, 3);
    chk("sub_opcode", opcode, 6'h21);
    chk("sub_len", cmd_len, 3'd1);
    chk("sub_imm", imm, 32'h0);

    // PUSH with immediate, then back-pressure
    prep(16'h0020, 8'h01, 32'h12345678, 1'b1);
    consume();
    wait_valid(n);
    chk("push_opcode", opcode, 6'h00);
    chk("push_sub", sub, 2'h1);
    chk("push_imm", imm, 32'h12345678);
    chk("push_len", cmd_len, 3'd5);
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp_valid_held", cmd_valid, 1'b1);
      chk("bp_no_req", mem_req, 1'b0);
    end

    // illegal opcode 0x05, new fetch from the new pc_in
    prep(16'h0030, 8'h14, 32'hA5A5A5A5, 1'b1);
    consume();
    chk("idle_after_consume", mem_req, 1'b0);
    @(posedge clk); #1;
    chk("refetch_addr", {mem_req, mem_addr}, {1'b1, 16'h0030});
    wait_valid(n);
    chk("illegal_flag", illegal, 1'b1);
    chk("illegal_len", cmd_len, 3'd1);
    chk("illegal_opcode", opcode, 6'h05);

    // flush during IMM with slow memory: drain, discard, refetch
    ack_delay = 4;
    prep(16'h0040, 8'h44, $urandom, 1'b0);
    addr_q.push_back(16'h0040);
    addr_q.push_back(16'h0041);
    addr_q.push_back(16'h0042);
    consume();
    wait_addr(16'h0042);
    flush = 1'b1;
    prep(16'h0050, 8'h8C, $urandom, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      chk("drain_req_addr", {mem_req, mem_addr}, {1'b1, 16'h0042});
      n++;
    end while (!mem_ack && n < 20);
    @(posedge clk); #1;
    chk("drain_to_idle", {mem_req, cmd_valid}, 2'b00);
    @(posedge clk); #1;
    chk("refetch_after_flush", {mem_req, mem_addr}, {1'b1, 16'h0050});
    wait_valid(n);

    // randomized commands with random memory latency and back-pressure
    for (int it = 0; it < 30; it++) begin
      ack_delay = $urandom_range(1, 3);
      if (it > 0) wait_valid(n);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 1) == 1) b = {lops[$urandom_range(0, 15)], 2'($urandom)};
      else b = 8'($urandom);
      prep(16'($urandom), b, $urandom, 1'b1);
      consume();
    end
    wait_valid(n);

    // address wrap
    ack_delay = 1;
    prep(16'hFFFE, 8'h01, $urandom, 1'b1);
    consume();
    wait_valid(n);
    chk("wrap_len", cmd_len, 3'd5);

    // asynchronous reset in the middle of an immediate fetch
    prep(16'hFFFE, 8'h00, $urandom, 1'b0);
    consume();
    addr_chk = 1'b0;
    wait_addr(16'h0000);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", mem_req, 1'b0);
    chk("async_rst_valid", cmd_valid, 1'b0);
    chk("async_rst_imm", imm, 32'h0);
    @(posedge clk); #1;
    addr_q.delete();
    addr_chk = 1'b1;
    prep(16'h0100, 8'h40, $urandom, 1'b1);
    @(negedge clk); rst_n = 1'b1;
    wait_valid(n);
    chk("post_rst_opcode", opcode, 6'h10);
    pc_in = 16'h0200;
    consume();
    addr_chk = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("addr_queue_empty", addr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
